// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: shared states, word tags and frame sizing for the CPU state streamer.
package cpu_dbg_pkg;
   typedef enum logic [2:0] {IDLE, HDR, MEM, REG, END} state_t;
   localparam logic [1:0] TAG_PC  = 2'd0;
   localparam logic [1:0] TAG_MEM = 2'd1;
   localparam logic [1:0] TAG_REG = 2'd2;
   localparam logic [1:0] TAG_END = 2'd3;
   localparam int FRAME_LEN = 66;
   function automatic int frame_len(input int mem_words, input int reg_num);
      return 2 + mem_words + reg_num;
   endfunction
endpackage

// File: rtl/dbg_out_reg.sv
// dbg_out_reg: single-entry valid/ready output register; refills on the cycle it empties.
module dbg_out_reg #(
   parameter int W = 35
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         ld_i,
   input  logic [W-1:0] d_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] q_o,
   output logic         can_ld_o
);
   assign can_ld_o = ~valid_o | ready_i;
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         valid_o <= 1'b0;
         q_o     <= '0;
      end else if (can_ld_o) begin
         valid_o <= ld_i;
         if (ld_i) q_o <= d_i;
      end
endmodule

// File: rtl/cpu_state_streamer.sv
// cpu_state_streamer: on request, freezes the core and streams PC, data memory and
// register file as a framed, tagged word stream.
module cpu_state_streamer
   import cpu_dbg_pkg::*;
#(
   parameter int DW        = 32,
   parameter int MEM_WORDS = 32,
   parameter int REG_NUM   = 32,
   parameter int CNT_W     = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             snap_req_i,
   input  logic [DW-1:0]    pc_i,
   output logic [4:0]       mem_addr_o,
   input  logic [DW-1:0]    mem_data_i,
   output logic [4:0]       rf_addr_o,
   input  logic [DW-1:0]    rf_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [DW-1:0]    out_data_o,
   output logic [1:0]       out_tag_o,
   output logic             out_last_o,
   output logic             busy_o,
   output logic             freeze_o,
   output logic [CNT_W-1:0] snap_cnt_o,
   output logic [CNT_W-1:0] drop_cnt_o
);
   state_t            state_q, state_d;
   logic [4:0]        idx_q, idx_d;
   logic [DW-1:0]     pc_q, pc_d;
   logic              pending_q, pending_d;
   logic [CNT_W-1:0]  snap_d, drop_d, snap_inc;
   logic              ld, can_ld, end_xfer;
   logic [DW+2:0]     d, q;

   assign snap_inc = &snap_cnt_o ? snap_cnt_o : snap_cnt_o + 1'b1;
   assign end_xfer = out_valid_o & out_ready_i & out_last_o;
   assign busy_o   = (state_q != IDLE) | pending_q;
   assign freeze_o = busy_o;
   assign {out_last_o, out_tag_o, out_data_o} = q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      pc_d       = pc_q;
      pending_d  = pending_q;
      snap_d     = snap_cnt_o;
      drop_d     = drop_cnt_o;
      ld         = 1'b0;
      d          = '0;
      mem_addr_o = '0;
      rf_addr_o  = '0;
      case (state_q)
         IDLE: if (snap_req_i | pending_q) begin
            pc_d      = pc_i;
            pending_d = 1'b0;
            state_d   = HDR;
         end
         HDR: begin
            ld = can_ld;
            d  = {1'b0, TAG_PC, pc_q};
            if (ld) begin
               idx_d   = '0;
               state_d = MEM;
            end
         end
         MEM: begin
            ld         = can_ld;
            mem_addr_o = ld ? idx_q : '0;
            d          = {1'b0, TAG_MEM, mem_data_i};
            if (ld) begin
               idx_d   = (idx_q == 5'(MEM_WORDS - 1)) ? '0 : idx_q + 5'd1;
               state_d = (idx_q == 5'(MEM_WORDS - 1)) ? REG : MEM;
            end
         end
         REG: begin
            ld        = can_ld;
            rf_addr_o = ld ? idx_q : '0;
            d         = {1'b0, TAG_REG, rf_data_i};
            if (ld) begin
               idx_d   = (idx_q == 5'(REG_NUM - 1)) ? '0 : idx_q + 5'd1;
               state_d = (idx_q == 5'(REG_NUM - 1)) ? END : REG;
            end
         end
         default: begin
            // END is loaded once; afterwards the register holds it until it drains
            ld = can_ld & ~(out_valid_o & out_last_o);
            d  = {1'b1, TAG_END, DW'(snap_inc)};
            if (end_xfer) begin
               snap_d  = snap_inc;
               state_d = IDLE;
            end
         end
      endcase
      if (state_q != IDLE && snap_req_i) begin
         pending_d = 1'b1;
         drop_d    = pending_q ? (&drop_cnt_o ? drop_cnt_o : drop_cnt_o + 1'b1) : drop_cnt_o;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         pc_q       <= '0;
         pending_q  <= 1'b0;
         snap_cnt_o <= '0;
         drop_cnt_o <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         pc_q       <= pc_d;
         pending_q  <= pending_d;
         snap_cnt_o <= snap_d;
         drop_cnt_o <= drop_d;
      end

   dbg_out_reg #(.W(DW + 3)) u_out (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .ld_i     (ld),
      .d_i      (d),
      .ready_i  (out_ready_i),
      .valid_o  (out_valid_o),
      .q_o      (q),
      .can_ld_o (can_ld)
   );
endmodule

// File: tb/tb_cpu_state_streamer.sv
// tb_cpu_state_streamer: frame-level scoreboard for the CPU state streamer.
module tb_cpu_state_streamer;
   logic        clk = 0, rst_n = 0, snap_req = 0, out_ready = 0;
   logic [31:0] pc = 0;
   logic [31:0] mem [32];
   logic [31:0] rf  [32];
   logic [4:0]  mem_addr, rf_addr, mem_addr2, rf_addr2;
   logic [31:0] out_data, out_data2;
   logic [1:0]  out_tag, out_tag2;
   logic        out_valid, out_last, busy, freeze, out_valid2, out_last2, busy2, freeze2;
   logic [15:0] snap_cnt, drop_cnt;
   logic [1:0]  snap_cnt2, drop_cnt2;
   int          errs = 0, checks = 0, cyc = 0, end_cnt = 0;
   logic [34:0] got [$];
   int          got_cyc [$];
   logic        stall = 0;
   logic [34:0] held;
   logic [31:0] sat_end = 0;

   typedef struct {
      logic [31:0] pc;
      int          rdy_pct;
      bit          rand_data;
      logic [31:0] exp_snap;
   } vec_t;
   vec_t vecs [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   cpu_state_streamer u_dut (
      .clk_i(clk), .rst_i(rst_n), .snap_req_i(snap_req), .pc_i(pc),
      .mem_addr_o(mem_addr), .mem_data_i(mem[mem_addr]),
      .rf_addr_o(rf_addr), .rf_data_i(rf[rf_addr]),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .out_tag_o(out_tag), .out_last_o(out_last), .busy_o(busy), .freeze_o(freeze),
      .snap_cnt_o(snap_cnt), .drop_cnt_o(drop_cnt)
   );

   cpu_state_streamer #(.CNT_W(2)) u_sat (
      .clk_i(clk), .rst_i(rst_n), .snap_req_i(snap_req), .pc_i(pc),
      .mem_addr_o(mem_addr2), .mem_data_i(mem[mem_addr2]),
      .rf_addr_o(rf_addr2), .rf_data_i(rf[rf_addr2]),
      .out_valid_o(out_valid2), .out_ready_i(out_ready), .out_data_o(out_data2),
      .out_tag_o(out_tag2), .out_last_o(out_last2), .busy_o(busy2), .freeze_o(freeze2),
      .snap_cnt_o(snap_cnt2), .drop_cnt_o(drop_cnt2)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) stall = 0;
      else begin
         if (stall) chk("stall hold", {out_valid, out_last, out_tag, out_data}, {1'b1, held});
         if (out_valid && out_ready) begin
            got.push_back({out_last, out_tag, out_data});
            got_cyc.push_back(cyc);
            if (out_last) end_cnt++;
         end
         if (out_valid2 && out_ready && out_last2) sat_end = out_data2;
         stall = out_valid && !out_ready;
         held  = {out_last, out_tag, out_data};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      snap_req = 1;
      tick();
      snap_req = 0;
   endtask

   task automatic wait_end(input int target, input int pct);
      for (int i = 0; i < 3000 && end_cnt < target; i++) begin
         out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
         tick();
      end
      chk("frame timeout", 64'(end_cnt >= target), 1);
      out_ready = 1;
   endtask

   task automatic check_frame(input string nm, input logic [31:0] fpc, input logic [31:0] endv);
      logic [34:0] e [$];
      int bad = 0;
      e.push_back({1'b0, 2'd0, fpc});
      for (int k = 0; k < 32; k++) e.push_back({1'b0, 2'd1, mem[k]});
      for (int k = 0; k < 32; k++) e.push_back({1'b0, 2'd2, rf[k]});
      e.push_back({1'b1, 2'd3, endv});
      chk({nm, " length"}, got.size(), e.size());
      for (int i = 0; i < e.size(); i++) if (i >= got.size() || got[i] !== e[i]) bad++;
      chk({nm, " bad words"}, bad, 0);
   endtask

   initial begin
      vecs[0] = '{32'h40, 100, 1'b0, 1};
      vecs[1] = '{32'h1234, 50, 1'b1, 2};
      vecs[2] = '{32'hdeadbeef, 25, 1'b1, 3};
      for (int k = 0; k < 32; k++) begin
         mem[k] = 0;
         rf[k] = 0;
      end
      #12;
      chk("reset outputs", {out_valid, busy, freeze, out_last, out_tag, out_data, mem_addr, rf_addr},
          '0);
      chk("reset counters", {snap_cnt, drop_cnt}, 0);
      tick();
      rst_n = 1;
      tick();
      tick();

      foreach (vecs[v]) begin
         for (int k = 0; k < 32; k++) begin
            mem[k] = vecs[v].rand_data ? $urandom : 32'(k + 100);
            rf[k]  = vecs[v].rand_data ? $urandom : 32'(k * 3);
         end
         pc = vecs[v].pc;
         got.delete();
         got_cyc.delete();
         out_ready = 1;
         pulse();
         chk("busy after req", {busy, freeze, out_valid}, 3'b110);
         tick();
         chk("first word valid", {out_valid, out_tag}, 3'b100);
         wait_end(v + 1, vecs[v].rdy_pct);
         chk("busy after end", busy, 0);
         check_frame($sformatf("vec%0d", v), vecs[v].pc, vecs[v].exp_snap);
         chk("snap count", snap_cnt, vecs[v].exp_snap);
         if (vecs[v].rdy_pct >= 100 && got_cyc.size() == 66)
            chk("back to back span", got_cyc[65] - got_cyc[0], 65);
      end
      chk("no drops", drop_cnt, 0);

      pc = 32'h80;
      got.delete();
      pulse();
      repeat (5) tick();
      pulse();
      repeat (3) tick();
      pulse();
      tick();
      pulse();
      chk("pending drops", drop_cnt, 2);
      wait_end(4, 100);
      chk("busy while pending", busy, 1);
      check_frame("overlap f1", 32'h80, 4);
      got.delete();
      tick();
      tick();
      chk("pending frame starts", {out_valid, out_tag}, 3'b100);
      wait_end(5, 100);
      check_frame("overlap f2", 32'h80, 5);
      chk("overlap snap", snap_cnt, 5);

      got.delete();
      pulse();
      for (int i = 0; i < 200 && !(out_valid && out_last); i++) tick();
      snap_req = 1;
      tick();
      snap_req = 0;
      chk("end req pending", {busy, out_valid}, 2'b10);
      chk("end req no drop", drop_cnt, 2);
      check_frame("endreq f1", 32'h80, 6);
      got.delete();
      tick();
      chk("gap busy", {busy, out_valid}, 2'b10);
      tick();
      chk("endreq restart", {busy, out_valid, out_tag}, 4'b1100);
      wait_end(7, 100);
      check_frame("endreq f2", 32'h80, 7);

      got.delete();
      pulse();
      for (int i = 0; i < 200 && got.size() < 20; i++) tick();
      #2 rst_n = 0;
      #1 chk("async reset", {out_valid, busy, freeze, snap_cnt, drop_cnt, snap_cnt2}, 0);
      tick();
      rst_n = 1;
      tick();
      chk("no end after abort", end_cnt, 7);
      for (int n = 1; n <= 5; n++) begin
         got.delete();
         pulse();
         wait_end(7 + n, 70);
         check_frame($sformatf("post reset %0d", n), 32'h80, 32'(n));
         chk("post reset snap", snap_cnt, 64'(n));
         chk("sat snap", snap_cnt2, 64'(n > 3 ? 3 : n));
         chk("sat end data", sat_end, 64'(n > 3 ? 3 : n));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
